vertex_stream_sequencer: RTL
============================

Name: vertex_stream_sequencer

Overview:
- Initiator and consumer for the MVP transform block. Drives its start/update_mvp handshake, sequences one camera-matrix update per frame, then feeds N vertices from vertex memory.
- Collects each projected (ox, oy, oz) float result, converts it to signed 16-bit screen coordinates, and emits a valid/ready stream toward the line/raster stage.

Parameters:
- NUM_VERTS, 64, vertices per frame; vertex addresses run 0..NUM_VERTS-1.
- ADDR_W, 6, vertex memory address width; must satisfy 2^ADDR_W >= NUM_VERTS.
- SCREEN_W, 640, pixel width; SCREEN_W/2 is added to the converted x.
- SCREEN_H, 480, pixel height; SCREEN_H/2 is added to the converted y.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse; ignored unless idle
- cam_roll, cam_pitch, cam_yaw  in  32 each  IEEE-754 angles; latched on accepted frame_start
- cam_x, cam_y, cam_z  in  32 each  camera position floats; latched on accepted frame_start
- vert_addr  out  ADDR_W  vertex memory address
- vert_data  in  96  {x[95:64], y[63:32], z[31:0]} floats; valid exactly 1 cycle after vert_addr changes
- mvp_start  out  1  one-cycle start pulse to the transform block
- mvp_update  out  1  update_mvp qualifier; valid while mvp_start is high
- mvp_roll, mvp_pitch, mvp_yaw  out  32 each  latched camera angles
- mvp_x, mvp_y, mvp_z  out  32 each  camera position during update; vertex during transform
- mvp_ox, mvp_oy, mvp_oz  in  32 each  projected result floats
- mvp_done  in  1  transform block idle (level, high when idle)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_x, out_y  out  16 each  signed screen coordinates
- out_last  out  1  marks the final emitted vertex of the frame
- busy  out  1  high in every state except S_IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state S_IDLE. All outputs 0, including mvp_start, out_valid, frame_done and vert_addr. Latched camera registers are cleared. Reset mid-frame aborts at once; no further mvp_start or out_valid is issued.
- S_IDLE: on frame_start && mvp_done, latch camera inputs and go to S_UPD_START. frame_start while busy is dropped, not queued.
- S_UPD_START (1 cycle): mvp_start=1, mvp_update=1, mvp_x/y/z=cam. Go to S_UPD_WAIT.
- S_UPD_WAIT: mvp_done is ignored in the first cycle after the start pulse. The first subsequent mvp_done=1 means complete; go to S_FETCH with vert_addr=0.
- S_FETCH (1 cycle, memory latency): go to S_XF_START.
- S_XF_START (1 cycle): mvp_start=1, mvp_update=0, mvp_x/y/z=vert_data fields, registered and held until the next start. Go to S_XF_WAIT.
- S_XF_WAIT: same done rule as S_UPD_WAIT; on completion, capture mvp_ox/oy/oz and go to S_CONVERT.
- S_CONVERT (1 cycle): float-to-int conversion.
  - Truncate toward zero.
  - Exponent < 127 gives 0.
  - Exponent 255 (inf/NaN), or magnitude >= 2^31, saturates by sign to a 32-bit int.
  - Add SCREEN_W/2 to x and SCREEN_H/2 to y, then saturate to [-32768, 32767].
  - Go to S_EMIT.
- S_EMIT: out_valid=1; out_x/out_y/out_last are held stable until handshake. On out_valid && out_ready:
  - last vertex: go to S_DONE;
  - otherwise: increment vert_addr and go to S_FETCH.
- out_last=1 only when vert_addr==NUM_VERTS-1.
- S_DONE (1 cycle): frame_done=1, then S_IDLE.
- Latency per vertex, excluding transform time and back-pressure: 4 cycles of sequencer overhead.
- out_ready held low stalls indefinitely. No data is dropped and no new mvp_start is issued while stalled.

Optional Feature:
- Macro VERTEX_DEPTH_CULL_EN.
- Defined: in S_CONVERT, a vertex with |oz| > 1.0 (exponent >= 127 and not exactly 1.0, or NaN) skips S_EMIT.
  - The culled vertex's index still advances.
  - If it is the last index, go directly to S_DONE; out_last is then not asserted for that frame.
  - A 16-bit culled-count register is readable on port cull_count, cleared on accepted frame_start.
- Undefined: every vertex is emitted, and port cull_count does not exist.

Decomposition:
- Package vertex_stream_pkg:
  - state enum;
  - FLOAT_ONE = 32'h3f800000;
  - vertex field slice positions;
  - int16 saturation limits.
- One sub-module, float_to_screen_int: combinational float-to-int32 truncate/saturate, instantiated twice (x and y).

Test Plan:
- frame_start with NUM_VERTS=1, vert x=42c90000 (100.5), transform model returning ox=42c90000, oy=c0700000 (-3.75), oz=0 -> update start pulse first (mvp_update=1, mvp_x=cam_x), then transform start with mvp_update=0; out_x=420, out_y=237, out_last=1, then frame_done pulse.
- ox=49742400 (1e6), oy=7f800000 (+inf) -> out_x=32767, out_y=32767; ox=ff800000 (-inf) -> out_x=-32768.
- out_ready low for 20 cycles on vertex 2 of 4 -> outputs held stable, no mvp_start issued, vert_addr=2 throughout; order 0..3 preserved.
- frame_start pulsed during S_XF_WAIT -> ignored; exactly NUM_VERTS outputs and one frame_done.
- reset asserted in S_XF_WAIT -> next cycle state S_IDLE, out_valid=0, vert_addr=0; a fresh frame then completes normally.
- VERTEX_DEPTH_CULL_EN defined, 3 vertices with oz=3f000000, 40000000, bf800000 -> 2 outputs (first and third), cull_count=1.

Source files
------------

// File: rtl/vertex_stream_pkg.sv
// Shared types and constants for the vertex stream sequencer: FSM states,
// vertex word layout and screen-coordinate saturation limits.
package vertex_stream_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UPD_START,
    S_UPD_WAIT,
    S_FETCH,
    S_XF_START,
    S_XF_WAIT,
    S_CONVERT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [31:0] FLOAT_ONE = 32'h3f800000;

  localparam int VTX_X_HI = 95;
  localparam int VTX_X_LO = 64;
  localparam int VTX_Y_HI = 63;
  localparam int VTX_Y_LO = 32;
  localparam int VTX_Z_HI = 31;
  localparam int VTX_Z_LO = 0;

  localparam logic signed [32:0] INT16_MAX = 33'sd32767;
  localparam logic signed [32:0] INT16_MIN = -33'sd32768;

  // Magnitude compare on the raw bits orders all finite values, inf and NaN above 1.0.
  function automatic logic exceeds_unit(input logic [31:0] f);
    return f[30:0] > FLOAT_ONE[30:0];
  endfunction

endpackage

// File: rtl/vertex_stream_sequencer_float_to_screen_int.sv
// Combinational IEEE-754 single to signed int32 conversion: truncates toward
// zero, flushes |f| < 1 to 0, saturates inf/NaN and |f| >= 2^31 by sign.
module float_to_screen_int
  import vertex_stream_pkg::*;
(
  input  logic        [31:0] fval,
  output logic signed [31:0] ival
);

  logic       sgn;
  logic [7:0] expo;
  logic [7:0] shamt;
  logic [31:0] mant;
  logic [31:0] mag;

  always_comb begin
    sgn   = fval[31];
    expo  = fval[30:23];
    mant  = {8'd0, 1'b1, fval[22:0]};
    shamt = 8'd0;
    mag   = 32'd0;
    ival  = 32'sd0;
    // Exponent 158 is 2^31; everything at or above it (including 255) saturates.
    if (expo == 8'hff || expo >= 8'd158) begin
      ival = sgn ? 32'sh80000000 : 32'sh7fffffff;
    end else if (expo >= 8'd127) begin
      shamt = expo - 8'd127;
      if (shamt >= 8'd23) begin
        mag = mant << (shamt - 8'd23);
      end else begin
        mag = mant >> (8'd23 - shamt);
      end
      ival = sgn ? -$signed(mag) : $signed(mag);
    end
  end

endmodule

// File: rtl/vertex_stream_sequencer.sv
// Drives the MVP transform block for one camera update plus NUM_VERTS vertices
// per frame and streams the projected screen coordinates downstream.
// Optional depth culling with cull_count port: define VERTEX_DEPTH_CULL_EN.
module vertex_stream_sequencer
  import vertex_stream_pkg::*;
#(
  parameter int NUM_VERTS = 64,
  parameter int ADDR_W    = 6,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [31:0]         cam_roll,
  input  logic [31:0]         cam_pitch,
  input  logic [31:0]         cam_yaw,
  input  logic [31:0]         cam_x,
  input  logic [31:0]         cam_y,
  input  logic [31:0]         cam_z,
  output logic [ADDR_W-1:0]   vert_addr,
  input  logic [95:0]         vert_data,
  output logic                mvp_start,
  output logic                mvp_update,
  output logic [31:0]         mvp_roll,
  output logic [31:0]         mvp_pitch,
  output logic [31:0]         mvp_yaw,
  output logic [31:0]         mvp_x,
  output logic [31:0]         mvp_y,
  output logic [31:0]         mvp_z,
  input  logic [31:0]         mvp_ox,
  input  logic [31:0]         mvp_oy,
  input  logic [31:0]         mvp_oz,
  input  logic                mvp_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [15:0]  out_x,
  output logic signed [15:0]  out_y,
  output logic                out_last,
`ifdef VERTEX_DEPTH_CULL_EN
  output logic [15:0]         cull_count,
`endif
  output logic                busy,
  output logic                frame_done
);

  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(NUM_VERTS - 1);
  localparam logic signed [31:0]  X_OFF     = 32'(SCREEN_W / 2);
  localparam logic signed [31:0]  Y_OFF     = 32'(SCREEN_H / 2);

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v,
                                               input logic signed [31:0] off);
    logic signed [32:0] s;
    s = $signed({v[31], v}) + $signed({off[31], off});
    if (s > INT16_MAX) return 16'sh7fff;
    if (s < INT16_MIN) return -16'sh8000;
    return s[15:0];
  endfunction

  state_t state, state_next;
  logic   wait_skip;
  logic   accept;
  logic   done_ok;
  logic   is_last;
  logic   cull_hit;

  logic [31:0] cam_roll_q, cam_pitch_q, cam_yaw_q;
  logic [31:0] cam_x_q, cam_y_q, cam_z_q;
  logic [31:0] vtx_x_p0, vtx_y_p0, vtx_z_p0;
  logic [31:0] res_ox_p1, res_oy_p1;
  logic signed [31:0] int_x_p1, int_y_p1;

  assign accept  = (state == S_IDLE) && frame_start && mvp_done;
  assign done_ok = !wait_skip && mvp_done;
  assign is_last = (vert_addr == LAST_ADDR);

`ifdef VERTEX_DEPTH_CULL_EN
  logic [31:0] res_oz_p1;
  assign cull_hit = exceeds_unit(res_oz_p1);
`else
  logic [31:0] unused_oz;
  assign unused_oz = mvp_oz;
  assign cull_hit  = 1'b0;
`endif

  float_to_screen_int u_conv_x (.fval(res_ox_p1), .ival(int_x_p1));
  float_to_screen_int u_conv_y (.fval(res_oy_p1), .ival(int_y_p1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_skip <= 1'b0;
    end else begin
      state     <= state_next;
      wait_skip <= (state == S_UPD_START) || (state == S_XF_START);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept) state_next = S_UPD_START;
      S_UPD_START: state_next = S_UPD_WAIT;
      S_UPD_WAIT:  if (done_ok) state_next = S_FETCH;
      S_FETCH:     state_next = S_XF_START;
      S_XF_START:  state_next = S_XF_WAIT;
      S_XF_WAIT:   if (done_ok) state_next = S_CONVERT;
      S_CONVERT: begin
        if (cull_hit) state_next = is_last ? S_DONE : S_FETCH;
        else          state_next = S_EMIT;
      end
      S_EMIT:      if (out_ready) state_next = is_last ? S_DONE : S_FETCH;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Stage p0: vertex fields captured as they are launched into the transform.
  // Stage p1: transform results captured on completion, converted in S_CONVERT.
  always_ff @(posedge clock) begin
    if (reset) begin
      vert_addr   <= '0;
      cam_roll_q  <= '0;
      cam_pitch_q <= '0;
      cam_yaw_q   <= '0;
      cam_x_q     <= '0;
      cam_y_q     <= '0;
      cam_z_q     <= '0;
      vtx_x_p0    <= '0;
      vtx_y_p0    <= '0;
      vtx_z_p0    <= '0;
      res_ox_p1   <= '0;
      res_oy_p1   <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_last    <= 1'b0;
`ifdef VERTEX_DEPTH_CULL_EN
      res_oz_p1   <= '0;
      cull_count  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cam_roll_q  <= cam_roll;
            cam_pitch_q <= cam_pitch;
            cam_yaw_q   <= cam_yaw;
            cam_x_q     <= cam_x;
            cam_y_q     <= cam_y;
            cam_z_q     <= cam_z;
            vert_addr   <= '0;
`ifdef VERTEX_DEPTH_CULL_EN
            cull_count  <= '0;
`endif
          end
        end
        S_UPD_WAIT: if (done_ok) vert_addr <= '0;
        S_XF_START: begin
          vtx_x_p0 <= vert_data[VTX_X_HI:VTX_X_LO];
          vtx_y_p0 <= vert_data[VTX_Y_HI:VTX_Y_LO];
          vtx_z_p0 <= vert_data[VTX_Z_HI:VTX_Z_LO];
        end
        S_XF_WAIT: begin
          if (done_ok) begin
            res_ox_p1 <= mvp_ox;
            res_oy_p1 <= mvp_oy;
`ifdef VERTEX_DEPTH_CULL_EN
            res_oz_p1 <= mvp_oz;
`endif
          end
        end
        S_CONVERT: begin
          out_x    <= sat16(int_x_p1, X_OFF);
          out_y    <= sat16(int_y_p1, Y_OFF);
          out_last <= is_last && !cull_hit;
`ifdef VERTEX_DEPTH_CULL_EN
          if (cull_hit) begin
            cull_count <= cull_count + 16'd1;
            if (!is_last) vert_addr <= vert_addr + ADDR_W'(1);
          end
`endif
        end
        S_EMIT: if (out_ready && !is_last) vert_addr <= vert_addr + ADDR_W'(1);
        S_DONE: vert_addr <= '0;
        default: ;
      endcase
    end
  end

  assign mvp_start  = (state == S_UPD_START) || (state == S_XF_START);
  assign mvp_update = (state == S_UPD_START);
  assign mvp_roll   = cam_roll_q;
  assign mvp_pitch  = cam_pitch_q;
  assign mvp_yaw    = cam_yaw_q;
  // Memory data is only valid during S_XF_START, so it is forwarded then and held after.
  assign mvp_x = (state == S_UPD_START) ? cam_x_q :
                 (state == S_XF_START)  ? vert_data[VTX_X_HI:VTX_X_LO] : vtx_x_p0;
  assign mvp_y = (state == S_UPD_START) ? cam_y_q :
                 (state == S_XF_START)  ? vert_data[VTX_Y_HI:VTX_Y_LO] : vtx_y_p0;
  assign mvp_z = (state == S_UPD_START) ? cam_z_q :
                 (state == S_XF_START)  ? vert_data[VTX_Z_HI:VTX_Z_LO] : vtx_z_p0;

  assign out_valid  = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule
